// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the RAM arbiter. The bus widths mirror the
// machine-wide architecture definitions.
package mem_arbiter_pkg;

  localparam int ARCH_ADDR_WIDTH = 16;
  localparam int ARCH_DATA_WIDTH = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    DRAIN    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  // On a conflict the requester that did not own the RAM last wins.
  function automatic owner_t rr_pick(input owner_t last_owner);
    return (last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin picker. Bit 0 is the CPU, bit 1 is the loader; the
// grant is combinational and the last owner is remembered at each grant.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  owner_t     r_last_owner;
  logic [1:0] w_req;

  assign w_req = i_req & ~i_mask & {2{i_en}};

  always_comb begin
    o_gnt = 2'b00;
    case (w_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (rr_pick(r_last_owner) == OWN_CPU) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Loader counts as last owner out of reset so the CPU wins the first conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_owner <= OWN_LDR;
    end else if (o_gnt[0]) begin
      r_last_owner <= OWN_CPU;
    end else if (o_gnt[1]) begin
      r_last_owner <= OWN_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port system RAM between the CPU and the program loader,
// with round-robin arbitration and an exclusive loader lock that stalls the CPU.
module mem_arbiter #(
  parameter int ADDR_WIDTH = mem_arbiter_pkg::ARCH_ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_arbiter_pkg::ARCH_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic                  ldr_gnt,
  output logic                  ldr_rvalid,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  input  logic                  ldr_lock,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  import mem_arbiter_pkg::*;

  lock_state_t r_lock_state;
  lock_state_t w_lock_next;
  logic [1:0]  w_req;
  logic [1:0]  w_mask;
  logic [1:0]  w_gnt;
  logic        w_cpu_block;
  logic        w_cpu_read_gnt;
  logic        w_ldr_read_gnt;
  logic        r_cpu_rvalid;
  logic        r_ldr_rvalid;

  // The CPU is shut out while draining and while the lock is held; when the
  // loader drops the lock the CPU may be granted in that very cycle.
  assign w_cpu_block = (r_lock_state == DRAIN) ||
                       ((r_lock_state == LOCKED) && ldr_lock);

  assign w_req  = {ldr_req, cpu_req};
  assign w_mask = {1'b0, w_cpu_block};

  rr_arbiter2 u_rr_arbiter2 (
    .clk    (clk),
    .reset  (reset),
    .i_req  (w_req),
    .i_mask (w_mask),
    .i_en   (reset),
    .o_gnt  (w_gnt)
  );

  assign cpu_gnt        = w_gnt[0];
  assign ldr_gnt        = w_gnt[1];
  assign w_cpu_read_gnt = w_gnt[0] & ~cpu_we;
  assign w_ldr_read_gnt = w_gnt[1] & ~ldr_we;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt[0]) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_gnt[1]) begin
      mem_en    = 1'b1;
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lock_state <= UNLOCKED;
    end else begin
      r_lock_state <= w_lock_next;
    end
  end

  // A CPU read granted as the lock rises must still deliver its data, so the
  // FSM spends one cycle in DRAIN before the lock takes hold.
  always_comb begin
    w_lock_next = r_lock_state;
    case (r_lock_state)
      UNLOCKED: begin
        if (ldr_lock) begin
          w_lock_next = w_cpu_read_gnt ? DRAIN : LOCKED;
        end
      end
      DRAIN: begin
        w_lock_next = LOCKED;
      end
      LOCKED: begin
        if (!ldr_lock) begin
          w_lock_next = UNLOCKED;
        end
      end
      default: begin
        w_lock_next = UNLOCKED;
      end
    endcase
  end

  // Read data is steered by these per-owner flags rather than by the current
  // grant, so a different requester may be granted while a read is returning.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpu_rvalid <= 1'b0;
      r_ldr_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_read_gnt;
      r_ldr_rvalid <= w_ldr_read_gnt;
    end
  end

  assign cpu_rvalid = r_cpu_rvalid;
  assign ldr_rvalid = r_ldr_rvalid;
  assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : '0;
  assign ldr_rdata  = r_ldr_rvalid ? mem_rdata : '0;

  assign cpu_stall = reset & (w_cpu_block | (cpu_req & ~w_gnt[0]));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a small RAM model answers the DUT and
// expected read data is queued at each predicted grant.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [AW-1:0] cpu_addr, ldr_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata;
  logic          cpu_gnt, cpu_rvalid, cpu_stall, ldr_gnt, ldr_rvalid;
  logic [DW-1:0] cpu_rdata, ldr_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  typedef struct {
    int          due;
    bit          to_cpu;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ram[256];
  logic [DW-1:0] shadow[256];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          exp_cv, exp_lv;
  logic [DW-1:0] exp_cd, exp_ld;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .ldr_lock   (ldr_lock),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous single-port RAM seen by the DUT; preloaded with addr+5.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = DW'(i + 5);
      shadow[i] = DW'(i + 5);
    end
  end

  task automatic push_read(input bit to_cpu, input logic [AW-1:0] addr);
    exp_t e;
    e.due    = cyc + 1;
    e.to_cpu = to_cpu;
    e.data   = shadow[addr[7:0]];
    sb.push_back(e);
  endtask

  task automatic pop_expected();
    exp_t e;
    exp_cv = 1'b0; exp_lv = 1'b0; exp_cd = '0; exp_ld = '0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due == cyc) begin
        if (e.to_cpu) begin exp_cv = 1'b1; exp_cd = e.data; end
        else          begin exp_lv = 1'b1; exp_ld = e.data; end
      end
    end
  endtask

  task automatic drive_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    ldr_lock = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    cpu_req = 1'b1; ldr_req = 1'b1; cpu_addr = 16'h0003; ldr_addr = 16'h0004;
    #12;
    n_cmp++; if (cpu_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL reset.cpu_gnt got %b want 0", cpu_gnt); end
    n_cmp++; if (ldr_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL reset.ldr_gnt got %b want 0", ldr_gnt); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("[TB] FAIL reset.mem_en got %b want 0", mem_en); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset.mem_addr got %h want 0000", mem_addr); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL reset.cpu_stall got %b want 0", cpu_stall); end
    n_cmp++; if ({cpu_rvalid, ldr_rvalid} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset.rvalid got %b want 00", {cpu_rvalid, ldr_rvalid}); end
    n_cmp++; if ({cpu_rdata, ldr_rdata} !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset.rdata got %h want 0000", {cpu_rdata, ldr_rdata}); end
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_cpu_read();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0003;
    @(negedge clk);
    n_cmp++; if ({cpu_gnt, ldr_gnt} !== 2'b10) begin n_bad++; $display("[TB] FAIL cpu_read.gnt got %b want 10", {cpu_gnt, ldr_gnt}); end
    n_cmp++; if ({mem_en, mem_we} !== 2'b10) begin n_bad++; $display("[TB] FAIL cpu_read.mem_en_we got %b want 10", {mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 16'h0003) begin n_bad++; $display("[TB] FAIL cpu_read.mem_addr got %h want 0003", mem_addr); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL cpu_read.stall got %b want 0", cpu_stall); end
    push_read(1'b1, 16'h0003);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    pop_expected();
    n_cmp++; if (cpu_rvalid !== exp_cv || cpu_rdata !== exp_cd) begin n_bad++; $display("[TB] FAIL cpu_read.rvalid_rdata got %b/%h want %b/%h", cpu_rvalid, cpu_rdata, exp_cv, exp_cd); end
    n_cmp++; if (ldr_rvalid !== exp_lv || ldr_rdata !== exp_ld) begin n_bad++; $display("[TB] FAIL cpu_read.ldr_out got %b/%h want %b/%h", ldr_rvalid, ldr_rdata, exp_lv, exp_ld); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("[TB] FAIL cpu_read.idle_mem_en got %b want 0", mem_en); end
  endtask

  task automatic test_alternate();
    bit model_last_ldr = 1'b1;
    bit win_cpu;
    do_reset();
    cpu_addr = 16'h0000; ldr_addr = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cpu_req = (i < 4); ldr_req = (i < 4);
      @(negedge clk);
      pop_expected();
      n_cmp++; if (cpu_rvalid !== exp_cv || cpu_rdata !== exp_cd) begin n_bad++; $display("[TB] FAIL alternate.cpu_rd[%0d] got %b/%h want %b/%h", i, cpu_rvalid, cpu_rdata, exp_cv, exp_cd); end
      n_cmp++; if (ldr_rvalid !== exp_lv || ldr_rdata !== exp_ld) begin n_bad++; $display("[TB] FAIL alternate.ldr_rd[%0d] got %b/%h want %b/%h", i, ldr_rvalid, ldr_rdata, exp_lv, exp_ld); end
      if (i < 4) begin
        win_cpu = model_last_ldr;
        n_cmp++; if ({cpu_gnt, ldr_gnt} !== {win_cpu, ~win_cpu}) begin n_bad++; $display("[TB] FAIL alternate.gnt[%0d] got %b want %b", i, {cpu_gnt, ldr_gnt}, {win_cpu, ~win_cpu}); end
        n_cmp++; if (cpu_stall !== ~win_cpu) begin n_bad++; $display("[TB] FAIL alternate.stall[%0d] got %b want %b", i, cpu_stall, ~win_cpu); end
        push_read(win_cpu, win_cpu ? 16'h0000 : 16'h0001);
        model_last_ldr = ~win_cpu;
      end
    end
  endtask

  task automatic test_write_then_read();
    @(posedge clk); #1;
    drive_idle();
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0010; ldr_wdata = 8'h5A;
    @(negedge clk);
    n_cmp++; if ({ldr_gnt, mem_en, mem_we} !== 3'b111) begin n_bad++; $display("[TB] FAIL wr_rd.write_ctl got %b want 111", {ldr_gnt, mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 16'h0010 || mem_wdata !== 8'h5A) begin n_bad++; $display("[TB] FAIL wr_rd.write_bus got %h/%h want 0010/5a", mem_addr, mem_wdata); end
    shadow[8'h10] = 8'h5A;
    @(posedge clk); #1;
    ldr_req = 1'b0; ldr_we = 1'b0;
    cpu_req = 1'b1; cpu_addr = 16'h0010;
    @(negedge clk);
    pop_expected();
    n_cmp++; if (ldr_rvalid !== exp_lv) begin n_bad++; $display("[TB] FAIL wr_rd.no_write_rvalid got %b want %b", ldr_rvalid, exp_lv); end
    n_cmp++; if ({cpu_gnt, mem_we} !== 2'b10) begin n_bad++; $display("[TB] FAIL wr_rd.read_gnt got %b want 10", {cpu_gnt, mem_we}); end
    push_read(1'b1, 16'h0010);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    pop_expected();
    n_cmp++; if (cpu_rvalid !== exp_cv || cpu_rdata !== exp_cd) begin n_bad++; $display("[TB] FAIL wr_rd.read_data got %b/%h want %b/%h", cpu_rvalid, cpu_rdata, exp_cv, exp_cd); end
  endtask

  task automatic test_lock();
    @(posedge clk); #1;
    drive_idle();
    cpu_req = 1'b1; cpu_addr = 16'h0002; ldr_lock = 1'b1;
    @(negedge clk);
    n_cmp++; if ({cpu_gnt, cpu_stall} !== 2'b10) begin n_bad++; $display("[TB] FAIL lock.rise_gnt_stall got %b want 10", {cpu_gnt, cpu_stall}); end
    push_read(1'b1, 16'h0002);
    @(posedge clk); #1;
    cpu_addr = 16'h0004; ldr_req = 1'b1; ldr_addr = 16'h0005;
    @(negedge clk);
    pop_expected();
    n_cmp++; if (cpu_rvalid !== exp_cv || cpu_rdata !== exp_cd) begin n_bad++; $display("[TB] FAIL lock.drain_rvalid got %b/%h want %b/%h", cpu_rvalid, cpu_rdata, exp_cv, exp_cd); end
    n_cmp++; if ({cpu_gnt, ldr_gnt, cpu_stall} !== 3'b011) begin n_bad++; $display("[TB] FAIL lock.drain_gnt_stall got %b want 011", {cpu_gnt, ldr_gnt, cpu_stall}); end
    push_read(1'b0, 16'h0005);
    @(posedge clk); #1;
    ldr_req = 1'b0;
    @(negedge clk);
    pop_expected();
    n_cmp++; if (ldr_rvalid !== exp_lv || ldr_rdata !== exp_ld || cpu_rvalid !== exp_cv) begin n_bad++; $display("[TB] FAIL lock.ldr_rvalid got %b/%h/%b want %b/%h/%b", ldr_rvalid, ldr_rdata, cpu_rvalid, exp_lv, exp_ld, exp_cv); end
    n_cmp++; if ({cpu_gnt, mem_en, cpu_stall} !== 3'b001) begin n_bad++; $display("[TB] FAIL lock.locked_idle got %b want 001", {cpu_gnt, mem_en, cpu_stall}); end
    @(posedge clk); #1;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0020; ldr_wdata = 8'h33;
    @(negedge clk);
    n_cmp++; if ({cpu_gnt, ldr_gnt, mem_we, cpu_stall} !== 4'b0111) begin n_bad++; $display("[TB] FAIL lock.locked_write got %b want 0111", {cpu_gnt, ldr_gnt, mem_we, cpu_stall}); end
    shadow[8'h20] = 8'h33;
    @(posedge clk); #1;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_lock = 1'b0; cpu_addr = 16'h0020;
    @(negedge clk);
    n_cmp++; if ({cpu_gnt, cpu_stall} !== 2'b10 || mem_addr !== 16'h0020) begin n_bad++; $display("[TB] FAIL lock.unlock_gnt got %b/%h want 10/0020", {cpu_gnt, cpu_stall}, mem_addr); end
    push_read(1'b1, 16'h0020);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    pop_expected();
    n_cmp++; if (cpu_rvalid !== exp_cv || cpu_rdata !== exp_cd) begin n_bad++; $display("[TB] FAIL lock.unlock_read got %b/%h want %b/%h", cpu_rvalid, cpu_rdata, exp_cv, exp_cd); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    drive_idle();
    cpu_req = 1'b1; cpu_addr = 16'h0001;
    @(negedge clk);
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL async_rst.pre_gnt got %b want 1", cpu_gnt); end
    @(posedge clk); #1;
    n_cmp++; if (cpu_rvalid !== 1'b1) begin n_bad++; $display("[TB] FAIL async_rst.pending got %b want 1", cpu_rvalid); end
    #1;
    cpu_req = 1'b0; reset = 1'b0; sb.delete();
    #1;
    n_cmp++; if ({cpu_rvalid, mem_en, cpu_stall} !== 3'b000 || cpu_rdata !== 8'h00) begin n_bad++; $display("[TB] FAIL async_rst.immediate got %b/%h want 000/00", {cpu_rvalid, mem_en, cpu_stall}, cpu_rdata); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b1; ldr_req = 1'b1; cpu_addr = 16'h0000; ldr_addr = 16'h0001;
    @(negedge clk);
    n_cmp++; if ({cpu_rvalid, ldr_rvalid} !== 2'b00) begin n_bad++; $display("[TB] FAIL async_rst.no_rvalid got %b want 00", {cpu_rvalid, ldr_rvalid}); end
    n_cmp++; if ({cpu_gnt, ldr_gnt} !== 2'b10) begin n_bad++; $display("[TB] FAIL async_rst.first_conflict got %b want 10", {cpu_gnt, ldr_gnt}); end
    push_read(1'b1, 16'h0000);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    pop_expected();
    n_cmp++; if (cpu_rvalid !== exp_cv || cpu_rdata !== exp_cd) begin n_bad++; $display("[TB] FAIL async_rst.after_read got %b/%h want %b/%h", cpu_rvalid, cpu_rdata, exp_cv, exp_cd); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    drive_idle();
    test_reset();
    test_cpu_read();
    test_alternate();
    test_write_then_read();
    test_lock();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous system RAM between two requesters: the CPU memory interface and the program loader (debug/hex load path).
- Sits between u_cpu/loader and u_ram in computer.
- Round-robin arbitration on conflict.
- Loader can lock the RAM exclusively, stalling the CPU, so a program image can be written before or during a run without contention.

Parameters:
- ADDR_WIDTH, 16, address width of the RAM bus (mirrors arch_defs_pkg).
- DATA_WIDTH, 8, data width (mirrors arch_defs_pkg).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until granted
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_gnt  out  1  access issued to RAM this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_WIDTH  CPU read data
- cpu_stall  out  1  CPU must hold its microstep (lock active or draining)
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  loader request, same semantics as CPU
- ldr_gnt, ldr_rvalid  out  1  loader grant / read valid
- ldr_rdata  out  DATA_WIDTH  loader read data
- ldr_lock  in  1  request exclusive RAM ownership for loader
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data (valid the cycle after mem_en with mem_we=0)

Behaviour:
- Reset (reset=0, async):
  - all gnt/rvalid/stall/mem_* outputs 0; rdata outputs 0.
  - last_owner=LDR; lock FSM=UNLOCKED.
- Grant is combinational in the issue cycle:
  - gnt=1 means mem_en=1 and mem_we/addr/wdata are driven from the winner that same cycle.
  - Requester samples gnt at the clock edge and may drop or change req afterwards.
- Arbitration (UNLOCKED):
  - Only one req → that requester wins.
  - Both req → the one not equal to last_owner wins.
  - last_owner updates at the edge of every grant.
  - No req → mem_en=0 and mem_addr/mem_wdata hold 0.
- Reads:
  - rvalid for the winner is registered: asserted exactly one cycle after a read grant, for one cycle.
  - rdata = mem_rdata while its rvalid=1, else 0.
  - Writes produce no rvalid.
- Back-to-back: a grant is allowed every cycle. A read grant followed by a grant to the other requester is legal, because rvalid is routed by a registered owner tag, not by the current grant.
- Lock FSM:
  - UNLOCKED → DRAIN when ldr_lock=1 and a CPU read was granted this cycle (rvalid pending next cycle).
  - UNLOCKED → LOCKED when ldr_lock=1 and no CPU read was granted this cycle.
  - DRAIN → LOCKED after one cycle (CPU rvalid delivered). In DRAIN, cpu_gnt=0 and ldr_gnt is allowed.
  - LOCKED: cpu_gnt forced 0; ldr granted whenever ldr_req.
  - LOCKED → UNLOCKED when ldr_lock=0. The CPU may be granted in the same cycle ldr_lock is seen low.
  - A CPU request arriving mid-DRAIN/LOCKED is held pending, not dropped (requester keeps req high).
- cpu_stall:
  - 1 in DRAIN and LOCKED.
  - 1 in UNLOCKED whenever cpu_req=1 and cpu_gnt=0 (lost arbitration).
  - 0 otherwise.
- Simultaneous ldr_lock rising and conflicting requests: lock evaluation takes precedence for the following cycle; current-cycle arbitration follows round-robin.
- Reset asserted mid-access: pending rvalid discarded; no rvalid after reset release.

Decomposition:
- arch_defs_pkg gains:
  - owner_t enum {OWN_CPU, OWN_LDR}
  - lock_state_t enum {UNLOCKED, DRAIN, LOCKED}
  - ADDR_WIDTH/DATA_WIDTH remain sourced from there.
- One natural sub-module: rr_arbiter2. It is a two-way round-robin picker holding last_owner, with inputs req[1:0], lock mask and grant enable, and outputs a one-hot gnt[1:0].
- Muxing, rvalid pipeline and lock FSM live in mem_arbiter.

Test Plan:
- CPU-only read 0x0003 (RAM holds 0x08) → cpu_gnt cycle N; cpu_rvalid=1, cpu_rdata=0x08 at N+1; ldr outputs 0.
- Both req every cycle after reset, reads of 0x0000/0x0001 → grants alternate CPU,LDR,CPU,LDR; each rvalid routed to its owner one cycle later.
- Loader write 0x5A to 0x0010 then CPU read 0x0010 → mem_we=1 cycle N, cpu_rvalid with 0x5A at N+2.
- ldr_lock raised the same cycle as a CPU read grant → DRAIN 1 cycle (cpu_rvalid delivered), then LOCKED. cpu_gnt stays 0 and cpu_stall=1 with cpu_req held. Dropping lock grants the CPU the same cycle.
- reset pulsed low asynchronously mid-clock during a pending read → all outputs 0 immediately; no rvalid after release; first conflict granted to CPU.
